gmii_rx_parser: RTL and testbench

- Receive-side counterpart of the GMII transmitter. Consumes the GMII byte stream from the Ethernet PHY, locks on preamble/SFD, filters on the Ethernet/IPv4/UDP headers, and unpacks the payload.
- Video payloads leave as 16-bit Y/C pixel words plus a 16-bit line header; audio payloads leave as 12-bit aux words plus the 16-bit AUXID.
- Sits between the PHY and the rx-side video/aux FIFOs, which are external and clocked on rx_clk.
- A per-frame commit/abort pulse tells the downstream logic whether the words already written belong to a good frame.

---
 rtl/gmii_pkg.sv | 54 +++++
 rtl/crc32_chk.sv | 51 +++++
 rtl/gmii_rx_parser.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_gmii_rx_parser.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_pkg.sv
// Shared definitions for the GMII receive parser: FSM states, header byte
// offsets, payload type codes and CRC constants.
package gmii_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_TYPE,
        ST_VRES,
        ST_VDATA,
        ST_AUXID,
        ST_AUX,
        ST_FCS,
        ST_DROP
    } rx_state_t;

    // Byte offsets counted from the first byte after the SFD.
    localparam logic [10:0] ETH_TYPE_OFS  = 11'd12;
    localparam logic [10:0] IP_VER_OFS    = 11'd14;
    localparam logic [10:0] IP_PROT_OFS   = 11'd23;
    localparam logic [10:0] UDP_DPORT_OFS = 11'd36;
    localparam logic [10:0] HDR_LEN       = 11'd42;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam logic [7:0] ETH_TYPE_HI   = 8'h08;
    localparam logic [7:0] ETH_TYPE_LO   = 8'h00;
    localparam logic [7:0] IP_VER_IHL    = 8'h45;
    localparam logic [7:0] IP_PROT_UDP   = 8'h11;

    localparam logic [7:0] PKT_VIDEO = 8'h00;
    localparam logic [7:0] PKT_AUDIO = 8'h01;

    // Residue of a good frame, shown MSB-first (bit-reversed register).
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

    // FCS bytes that make up a complete trailer.
    localparam logic [10:0] FCS_LEN = 11'd4;

    // Byte idx (0 = first on the wire) of a 48-bit MAC address.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (idx == 3'(i)) begin
                b = mac[8*(5-i) +: 8];
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/crc32_chk.sv
// Byte-wide reflected CRC-32 (Ethernet polynomial). The register shifts
// LSB first; the output is presented bit-reversed so a good frame leaves
// the familiar 32'hC704DD7B residue.
module crc32_chk
    import gmii_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    // Next register value: preset on init, otherwise fold in one byte LSB first.
    always_comb begin
        lfsr_d = lfsr_q;
        if (init) begin
            lfsr_d = 32'hFFFF_FFFF;
        end else if (en) begin
            for (int i = 0; i < 8; i++) begin
                if (lfsr_d[0] ^ data[i]) begin
                    lfsr_d = (lfsr_d >> 1) ^ CRC_POLY_REFL;
                end else begin
                    lfsr_d = lfsr_d >> 1;
                end
            end
        end
    end

    // CRC register, preset to all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 32'hFFFF_FFFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Present the register MSB-first.
    always_comb begin
        crc = 32'h0;
        for (int i = 0; i < 32; i++) begin
            crc[i] = lfsr_q[31-i];
        end
    end

endmodule

// File: rtl/gmii_rx_parser.sv
// GMII receive parser: locks on preamble/SFD, filters Ethernet/IPv4/UDP
// headers, unpacks video pixel words or audio aux samples, and closes each
// accepted frame with a pkt_done (good FCS) or pkt_err (abort) pulse.
//
// Handshake: the downstream FIFOs have no back-pressure. vid_wr_en and
// aux_wr_en are single-cycle write strobes; the data bus is valid in the
// same cycle as its strobe. vid_line/aux_id are valid from their _vld pulse
// until the next one.
module gmii_rx_parser
    import gmii_pkg::*;
#(
    parameter logic [47:0] my_mac    = 48'h002345678902,
    parameter logic [15:0] udp_port  = 16'h3039,
    parameter logic [10:0] vid_bytes = 11'd1280,
    parameter logic [5:0]  aux_bytes = 6'd48
) (
    input  logic        rx_clk,
    input  logic        sys_rst,
    input  logic        id,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rxd,
    output logic [15:0] vid_line,
    output logic        vid_line_vld,
    output logic        vid_wr_en,
    output logic [15:0] vid_din,
    output logic [15:0] aux_id,
    output logic        aux_id_vld,
    output logic        aux_wr_en,
    output logic [11:0] aux_din,
    output logic        pkt_done,
    output logic        pkt_err
);

    localparam logic [10:0] VID_LAST = vid_bytes - 11'd1;
    localparam logic [10:0] AUX_LAST = {5'd0, aux_bytes} - 11'd1;

    rx_state_t   state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [1:0]  ph_q, ph_d;
    logic [7:0]  hold_q, hold_d;
    logic [3:0]  left_q, left_d;

    logic [15:0] vid_line_q, vid_line_d;
    logic        vid_line_vld_q, vid_line_vld_d;
    logic        vid_wr_en_q, vid_wr_en_d;
    logic [15:0] vid_din_q, vid_din_d;
    logic [15:0] aux_id_q, aux_id_d;
    logic        aux_id_vld_q, aux_id_vld_d;
    logic        aux_wr_en_q, aux_wr_en_d;
    logic [11:0] aux_din_q, aux_din_d;
    logic        pkt_done_q, pkt_done_d;
    logic        pkt_err_q, pkt_err_d;

    logic        crc_init;
    logic        crc_en;
    logic [31:0] crc;
    logic        hdr_ok;
    logic        in_payload;

    crc32_chk u_crc (
        .clk  (rx_clk),
        .rst  (sys_rst),
        .init (crc_init),
        .en   (crc_en),
        .data (rxd),
        .crc  (crc)
    );

    // CRC covers every byte from the first one after the SFD through the FCS.
    assign crc_en = rx_dv && (state_q inside {ST_HDR, ST_TYPE, ST_VRES, ST_VDATA,
                                              ST_AUXID, ST_AUX, ST_FCS});

    // Past the type byte, losing rx_dv or seeing rx_er aborts with pkt_err.
    assign in_payload = state_q inside {ST_VRES, ST_VDATA, ST_AUXID, ST_AUX};

    // Compare the current header byte with its required value; unchecked bytes pass.
    always_comb begin
        hdr_ok = 1'b1;
        if (cnt_q < 11'd5) begin
            hdr_ok = (rxd == mac_byte(my_mac, cnt_q[2:0]));
        end else if (cnt_q == 11'd5) begin
            hdr_ok = (rxd == (my_mac[7:0] - {7'd0, id}));
        end else if (cnt_q == ETH_TYPE_OFS) begin
            hdr_ok = (rxd == ETH_TYPE_HI);
        end else if (cnt_q == ETH_TYPE_OFS + 11'd1) begin
            hdr_ok = (rxd == ETH_TYPE_LO);
        end else if (cnt_q == IP_VER_OFS) begin
            hdr_ok = (rxd == IP_VER_IHL);
        end else if (cnt_q == IP_PROT_OFS) begin
            hdr_ok = (rxd == IP_PROT_UDP);
        end else if (cnt_q == UDP_DPORT_OFS) begin
            hdr_ok = (rxd == udp_port[15:8]);
        end else if (cnt_q == UDP_DPORT_OFS + 11'd1) begin
            hdr_ok = (rxd == udp_port[7:0]);
        end
    end

    // Next-state, counters and next output values.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ph_d           = ph_q;
        hold_d         = hold_q;
        left_d         = left_q;
        vid_line_d     = vid_line_q;
        vid_line_vld_d = 1'b0;
        vid_wr_en_d    = 1'b0;
        vid_din_d      = vid_din_q;
        aux_id_d       = aux_id_q;
        aux_id_vld_d   = 1'b0;
        aux_wr_en_d    = 1'b0;
        aux_din_d      = aux_din_q;
        pkt_done_d     = 1'b0;
        pkt_err_d      = 1'b0;
        crc_init       = 1'b0;

        if (in_payload && (!rx_dv || rx_er)) begin
            pkt_err_d = 1'b1;
            state_d   = rx_dv ? ST_DROP : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_dv) begin
                        state_d = (rxd == PREAMBLE_BYTE && !rx_er) ? ST_PRE : ST_DROP;
                    end
                end
                ST_PRE: begin
                    if (!rx_dv) begin
                        state_d = ST_IDLE;
                    end else if (rx_er) begin
                        state_d = ST_DROP;
                    end else if (rxd == SFD_BYTE) begin
                        state_d  = ST_HDR;
                        cnt_d    = 11'd0;
                        crc_init = 1'b1;
                    end else if (rxd != PREAMBLE_BYTE) begin
                        state_d = ST_DROP;
                    end
                end
                ST_HDR: begin
                    if (!rx_dv) begin
                        state_d = ST_IDLE;
                    end else if (rx_er || !hdr_ok) begin
                        state_d = ST_DROP;
                    end else if (cnt_q == HDR_LEN - 11'd1) begin
                        state_d = ST_TYPE;
                        cnt_d   = 11'd0;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
                ST_TYPE: begin
                    if (!rx_dv) begin
                        state_d = ST_IDLE;
                    end else if (rx_er) begin
                        state_d = ST_DROP;
                    end else if (rxd == PKT_VIDEO) begin
                        state_d = ST_VRES;
                        cnt_d   = 11'd0;
                    end else if (rxd == PKT_AUDIO) begin
                        state_d = ST_AUXID;
                        cnt_d   = 11'd0;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                ST_VRES: begin
                    if (cnt_q == 11'd0) begin
                        hold_d = rxd;
                        cnt_d  = 11'd1;
                    end else begin
                        vid_line_d     = {hold_q, rxd};
                        vid_line_vld_d = 1'b1;
                        state_d        = ST_VDATA;
                        cnt_d          = 11'd0;
                    end
                end
                ST_VDATA: begin
                    if (!cnt_q[0]) begin
                        hold_d = rxd;
                    end else begin
                        vid_din_d   = {hold_q, rxd};
                        vid_wr_en_d = 1'b1;
                    end
                    if (cnt_q == VID_LAST) begin
                        state_d = ST_FCS;
                        cnt_d   = 11'd0;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
                ST_AUXID: begin
                    if (cnt_q == 11'd0) begin
                        hold_d = rxd;
                        cnt_d  = 11'd1;
                    end else begin
                        aux_id_d     = {rxd, hold_q};
                        aux_id_vld_d = 1'b1;
                        left_d       = rxd[7:4];
                        state_d      = ST_AUX;
                        cnt_d        = 11'd0;
                        ph_d         = 2'd0;
                    end
                end
                ST_AUX: begin
                    // Two 12-bit samples are packed into each 3-byte group.
                    case (ph_q)
                        2'd0: begin
                            hold_d = rxd;
                            ph_d   = 2'd1;
                        end
                        2'd1: begin
                            aux_din_d   = {rxd[3:0], hold_q};
                            aux_wr_en_d = 1'b1;
                            hold_d      = rxd;
                            ph_d        = 2'd2;
                        end
                        default: begin
                            aux_din_d   = {rxd, hold_q[7:4]};
                            aux_wr_en_d = 1'b1;
                            ph_d        = 2'd0;
                        end
                    endcase
                    if (cnt_q == AUX_LAST) begin
                        state_d = (left_q == 4'd0) ? ST_FCS : ST_AUXID;
                        cnt_d   = 11'd0;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
                ST_FCS: begin
                    if (!rx_dv) begin
                        if (cnt_q == FCS_LEN && crc == CRC_RESIDUE) begin
                            pkt_done_d = 1'b1;
                        end else begin
                            pkt_err_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else if (rx_er || cnt_q == FCS_LEN) begin
                        pkt_err_d = 1'b1;
                        state_d   = ST_DROP;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
                ST_DROP: begin
                    if (!rx_dv) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge rx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 11'd0;
            ph_q           <= 2'd0;
            hold_q         <= 8'd0;
            left_q         <= 4'd0;
            vid_line_q     <= 16'd0;
            vid_line_vld_q <= 1'b0;
            vid_wr_en_q    <= 1'b0;
            vid_din_q      <= 16'd0;
            aux_id_q       <= 16'd0;
            aux_id_vld_q   <= 1'b0;
            aux_wr_en_q    <= 1'b0;
            aux_din_q      <= 12'd0;
            pkt_done_q     <= 1'b0;
            pkt_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ph_q           <= ph_d;
            hold_q         <= hold_d;
            left_q         <= left_d;
            vid_line_q     <= vid_line_d;
            vid_line_vld_q <= vid_line_vld_d;
            vid_wr_en_q    <= vid_wr_en_d;
            vid_din_q      <= vid_din_d;
            aux_id_q       <= aux_id_d;
            aux_id_vld_q   <= aux_id_vld_d;
            aux_wr_en_q    <= aux_wr_en_d;
            aux_din_q      <= aux_din_d;
            pkt_done_q     <= pkt_done_d;
            pkt_err_q      <= pkt_err_d;
        end
    end

    assign vid_line     = vid_line_q;
    assign vid_line_vld = vid_line_vld_q;
    assign vid_wr_en    = vid_wr_en_q;
    assign vid_din      = vid_din_q;
    assign aux_id       = aux_id_q;
    assign aux_id_vld   = aux_id_vld_q;
    assign aux_wr_en    = aux_wr_en_q;
    assign aux_din      = aux_din_q;
    assign pkt_done     = pkt_done_q;
    assign pkt_err      = pkt_err_q;

endmodule

// File: tb/tb_gmii_rx_parser.sv
// Bench for gmii_rx_parser: frames are assembled byte by byte from field
// descriptions, the expected output words are derived from the payload
// layout, and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_gmii_rx_parser;

    localparam int M_OK     = 0;
    localparam int M_DVDROP = 1;
    localparam int M_RXER   = 2;
    localparam int M_RST    = 3;
    localparam int M_EXTRA  = 4;

    logic        rx_clk = 1'b0;
    logic        sys_rst;
    logic        id;
    logic        rx_dv;
    logic        rx_er;
    logic [7:0]  rxd;
    logic [15:0] vid_line;
    logic        vid_line_vld;
    logic        vid_wr_en;
    logic [15:0] vid_din;
    logic [15:0] aux_id;
    logic        aux_id_vld;
    logic        aux_wr_en;
    logic [11:0] aux_din;
    logic        pkt_done;
    logic        pkt_err;

    int total = 0;
    int bad   = 0;

    // Scoreboard queues.
    logic [15:0] exp_line_q[$];
    logic [15:0] exp_vid_q[$];
    logic [15:0] exp_auxid_q[$];
    logic [11:0] exp_aux_q[$];
    logic [1:0]  exp_evt_q[$];   // 2'b01 done, 2'b10 err

    // Current frame (bytes after SFD) and the payload words it carries.
    logic [7:0]  fb[$];
    logic [1:0]  it_kind[$];     // 0 line, 1 pixel word, 2 aux id, 3 aux sample
    logic [15:0] it_val[$];
    int          it_end[$];      // offset of the word's last byte

    // ---------------- clock / reset ----------------
    always #4 rx_clk = ~rx_clk;

    initial begin
        #700000;
        $display("FAIL watchdog: simulation time exceeded, want finish before 700us");
        $fatal(1, "watchdog");
    end

    gmii_rx_parser dut (
        .rx_clk       (rx_clk),
        .sys_rst      (sys_rst),
        .id           (id),
        .rx_dv        (rx_dv),
        .rx_er        (rx_er),
        .rxd          (rxd),
        .vid_line     (vid_line),
        .vid_line_vld (vid_line_vld),
        .vid_wr_en    (vid_wr_en),
        .vid_din      (vid_din),
        .aux_id       (aux_id),
        .aux_id_vld   (aux_id_vld),
        .aux_wr_en    (aux_wr_en),
        .aux_din      (aux_din),
        .pkt_done     (pkt_done),
        .pkt_err      (pkt_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: got strobe want none", name);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vid_line"},     32'(vid_line), 32'h0);
        chk({tag, "_vid_line_vld"}, 32'(vid_line_vld), 32'h0);
        chk({tag, "_vid_wr_en"},    32'(vid_wr_en), 32'h0);
        chk({tag, "_vid_din"},      32'(vid_din), 32'h0);
        chk({tag, "_aux_id"},       32'(aux_id), 32'h0);
        chk({tag, "_aux_id_vld"},   32'(aux_id_vld), 32'h0);
        chk({tag, "_aux_wr_en"},    32'(aux_wr_en), 32'h0);
        chk({tag, "_aux_din"},      32'(aux_din), 32'h0);
        chk({tag, "_pkt_done"},     32'(pkt_done), 32'h0);
        chk({tag, "_pkt_err"},      32'(pkt_err), 32'h0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge rx_clk) begin
        if (!sys_rst) begin
            if (vid_line_vld) begin
                if (exp_line_q.size() == 0) unexpected("vid_line_vld");
                else chk("vid_line", 32'(vid_line), 32'(exp_line_q.pop_front()));
            end
            if (vid_wr_en) begin
                if (exp_vid_q.size() == 0) unexpected("vid_wr_en");
                else chk("vid_din", 32'(vid_din), 32'(exp_vid_q.pop_front()));
            end
            if (aux_id_vld) begin
                if (exp_auxid_q.size() == 0) unexpected("aux_id_vld");
                else chk("aux_id", 32'(aux_id), 32'(exp_auxid_q.pop_front()));
            end
            if (aux_wr_en) begin
                if (exp_aux_q.size() == 0) unexpected("aux_wr_en");
                else chk("aux_din", 32'(aux_din), 32'(exp_aux_q.pop_front()));
            end
            if (pkt_done || pkt_err) begin
                if (exp_evt_q.size() == 0) unexpected("pkt_done_err");
                else chk("pkt_evt{err,done}", 32'({pkt_err, pkt_done}), 32'(exp_evt_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic put(input logic dv, input logic er, input logic [7:0] d);
        rx_dv = dv;
        rx_er = er;
        rxd   = d;
        @(posedge rx_clk);
        #1;
    endtask

    task automatic add_item(input logic [1:0] k, input logic [15:0] v);
        it_kind.push_back(k);
        it_val.push_back(v);
        it_end.push_back(fb.size() - 1);
    endtask

    task automatic build_hdr(input logic [7:0] dst_low, input logic [15:0] dport,
                             input logic [7:0] prot);
        fb.delete();
        it_kind.delete();
        it_val.delete();
        it_end.delete();
        fb.push_back(8'h00); fb.push_back(8'h23); fb.push_back(8'h45);
        fb.push_back(8'h67); fb.push_back(8'h89); fb.push_back(dst_low);
        repeat (6) fb.push_back(8'($urandom));        // source MAC
        fb.push_back(8'h08); fb.push_back(8'h00);     // EtherType IPv4
        fb.push_back(8'h45);                          // version/IHL
        repeat (8) fb.push_back(8'($urandom));        // IP bytes 15..22
        fb.push_back(prot);                           // IP protocol
        repeat (12) fb.push_back(8'($urandom));       // IP rest + UDP src port
        fb.push_back(dport[15:8]); fb.push_back(dport[7:0]);
        repeat (4) fb.push_back(8'($urandom));        // UDP length + checksum
    endtask

    task automatic build_video(input bit seq, input logic [7:0] ptype);
        logic [7:0] l0, l1, b;
        fb.push_back(ptype);
        l0 = seq ? 8'h12 : 8'($urandom);
        l1 = seq ? 8'h34 : 8'($urandom);
        fb.push_back(l0);
        fb.push_back(l1);
        add_item(2'd0, {l0, l1});
        for (int k = 0; k < 1280; k++) begin
            b = seq ? 8'(k) : 8'($urandom);
            fb.push_back(b);
            if (k % 2 == 1) add_item(2'd1, {fb[fb.size()-2], b});
        end
    endtask

    task automatic build_audio(input int nblk, input bit spec_pat);
        logic [7:0] c0, c1, b0, b1, b2;
        fb.push_back(8'h01);
        for (int blk = 0; blk < nblk; blk++) begin
            if (spec_pat) begin
                c0 = (blk == 0) ? 8'h34 : 8'h78;
                c1 = (blk == 0) ? 8'h12 : 8'h05;
            end else begin
                c0 = 8'($urandom);
                c1 = {(blk == nblk - 1) ? 4'd0 : 4'($urandom_range(1, 15)), 4'($urandom)};
            end
            fb.push_back(c0);
            fb.push_back(c1);
            add_item(2'd2, {c1, c0});
            for (int g = 0; g < 16; g++) begin
                if (spec_pat && g == 0) begin
                    b0 = 8'hAB; b1 = 8'hCD; b2 = 8'hEF;
                end else begin
                    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
                end
                fb.push_back(b0);
                fb.push_back(b1);
                add_item(2'd3, {4'h0, b1[3:0], b0});
                fb.push_back(b2);
                add_item(2'd3, {b2, b1[7:4]});
            end
        end
    endtask

    // Append the Ethernet FCS (complemented CRC-32, LSB byte first); flip >= 0 corrupts one bit.
    task automatic add_fcs(input int flip);
        logic [31:0] c;
        int          p;
        c = 32'hFFFF_FFFF;
        foreach (fb[i]) begin
            c = c ^ {24'h0, fb[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        fb.push_back(c[7:0]); fb.push_back(c[15:8]);
        fb.push_back(c[23:16]); fb.push_back(c[31:24]);
        if (flip >= 0) begin
            p = fb.size() - 4 + flip / 8;
            fb[p] = fb[p] ^ (8'h01 << (flip % 8));
        end
    endtask

    task automatic do_reset_mid_frame();
        #4;
        sys_rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        #1;
        sys_rst = 1'b0;
    endtask

    // Push expectations, then drive preamble, SFD, frame and gap.
    task automatic run_frame(input bit accepted, input int mode, input int cut, input bit fcs_bad);
        int lim;
        lim = (mode == M_OK || mode == M_EXTRA) ? fb.size() : cut;
        if (accepted) begin
            foreach (it_end[i]) begin
                if (it_end[i] < lim) begin
                    case (it_kind[i])
                        2'd0: exp_line_q.push_back(it_val[i]);
                        2'd1: exp_vid_q.push_back(it_val[i]);
                        2'd2: exp_auxid_q.push_back(it_val[i]);
                        default: exp_aux_q.push_back(it_val[i][11:0]);
                    endcase
                end
            end
            if (mode != M_RST) exp_evt_q.push_back((mode == M_OK && !fcs_bad) ? 2'b01 : 2'b10);
        end
        if (mode == M_EXTRA) fb.push_back(8'($urandom));
        repeat ($urandom_range(1, 7)) put(1'b1, 1'b0, 8'h55);
        put(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < fb.size(); i++) begin
            if (mode == M_DVDROP && i == cut) break;
            put(1'b1, (mode == M_RXER && i == cut), fb[i]);
            if (mode == M_RST && i == cut - 1) do_reset_mid_frame();
        end
        repeat ($urandom_range(1, 3)) put(1'b0, 1'b0, 8'($urandom));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  kind, mode, cut;
        bit  fb_bad;
        sys_rst = 1'b1;
        id      = 1'b0;
        rx_dv   = 1'b0;
        rx_er   = 1'b0;
        rxd     = 8'h00;
        #1;
        chk_all_zero("reset");
        repeat (3) @(posedge rx_clk);
        #1;
        sys_rst = 1'b0;
        repeat (2) put(1'b0, 1'b0, 8'h00);

        // Good video frame, spec pattern.
        build_hdr(8'h02, 16'h3039, 8'h11); build_video(1, 8'h00); add_fcs(-1);
        run_frame(1, M_OK, 0, 0);
        // Wrong destination MAC low byte with id=0: silently dropped.
        build_hdr(8'h03, 16'h3039, 8'h11); build_video(1, 8'h00); add_fcs(-1);
        run_frame(0, M_OK, 0, 0);
        // id=1 expects low byte 01.
        id = 1'b1;
        build_hdr(8'h01, 16'h3039, 8'h11); build_video(1, 8'h00); add_fcs(-1);
        run_frame(1, M_OK, 0, 0);
        build_hdr(8'h02, 16'h3039, 8'h11); build_video(0, 8'h00); add_fcs(-1);
        run_frame(0, M_OK, 0, 0);
        id = 1'b0;
        // Audio frame, two blocks.
        build_hdr(8'h02, 16'h3039, 8'h11); build_audio(2, 1); add_fcs(-1);
        run_frame(1, M_OK, 0, 0);
        // FCS bit flipped.
        build_hdr(8'h02, 16'h3039, 8'h11); build_video(1, 8'h00); add_fcs($urandom_range(0, 31));
        run_frame(1, M_OK, 0, 1);
        // rx_dv dropped after 100 pixel bytes, then a good frame.
        build_hdr(8'h02, 16'h3039, 8'h11); build_video(1, 8'h00); add_fcs(-1);
        run_frame(1, M_DVDROP, 45 + 100, 0);
        build_hdr(8'h02, 16'h3039, 8'h11); build_video(0, 8'h00); add_fcs(-1);
        run_frame(1, M_OK, 0, 0);
        // rx_er at pixel byte 10.
        build_hdr(8'h02, 16'h3039, 8'h11); build_video(1, 8'h00); add_fcs(-1);
        run_frame(1, M_RXER, 45 + 10, 0);
        // Reset mid-VDATA, then a good frame.
        build_hdr(8'h02, 16'h3039, 8'h11); build_video(1, 8'h00); add_fcs(-1);
        run_frame(1, M_RST, 45 + 301, 0);
        build_hdr(8'h02, 16'h3039, 8'h11); build_audio(1, 0); add_fcs(-1);
        run_frame(1, M_OK, 0, 0);
        // Fifth FCS byte, dv drop right after type, bad type/port/protocol.
        build_hdr(8'h02, 16'h3039, 8'h11); build_audio(2, 0); add_fcs(-1);
        run_frame(1, M_EXTRA, 0, 0);
        build_hdr(8'h02, 16'h3039, 8'h11); build_video(0, 8'h00); add_fcs(-1);
        run_frame(1, M_DVDROP, 43, 0);
        build_hdr(8'h02, 16'h3039, 8'h11); build_video(0, 8'h02); add_fcs(-1);
        run_frame(0, M_OK, 0, 0);
        build_hdr(8'h02, 16'h3040, 8'h11); build_audio(1, 0); add_fcs(-1);
        run_frame(0, M_OK, 0, 0);
        build_hdr(8'h02, 16'h3039, 8'h06); build_audio(1, 0); add_fcs(-1);
        run_frame(0, M_OK, 0, 0);

        // Randomised frames.
        for (int n = 0; n < 8; n++) begin
            kind   = $urandom_range(0, 1);
            mode   = $urandom_range(0, 2);
            fb_bad = ($urandom_range(0, 3) == 0);
            build_hdr(8'h02, 16'h3039, 8'h11);
            if (kind == 0) build_video(0, 8'h00);
            else build_audio($urandom_range(1, 3), 0);
            add_fcs(fb_bad ? int'($urandom_range(0, 31)) : -1);
            cut = $urandom_range(43, fb.size() - 1);
            run_frame(1, mode, cut, fb_bad);
        end

        repeat (5) put(1'b0, 1'b0, 8'h00);
        chk("left_line",  32'(exp_line_q.size()), 32'h0);
        chk("left_vid",   32'(exp_vid_q.size()), 32'h0);
        chk("left_auxid", 32'(exp_auxid_q.size()), 32'h0);
        chk("left_aux",   32'(exp_aux_q.size()), 32'h0);
        chk("left_evt",   32'(exp_evt_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
